seq_chk_param: RTL
==================

SEQ_CHK_PARAM -- requirements
Module: seq_chk_param

Interface
REQ-001 Parameter FIELD_W, default 12, width of one counter field.
REQ-002 Parameter NFIELD, default 16, fields per word; SHALL be a power of two >= 4.
REQ-003 Parameter TS_W, default 32, timestamp width; TS_F = ceil(TS_W/FIELD_W) low fields carry it in timestamp mode; TS_F < NFIELD.
REQ-004 Parameter LOCK_CNT, default 4, consecutive good words needed to lock.
REQ-005 Parameter LOSS_CNT, default 8, consecutive bad words that drop lock.
REQ-006 Parameter WIN, default 1000, words per bandwidth window.
REQ-007 Parameter LAT_CAP, default 50, latency samples >= LAT_CAP are excluded from max.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 data  in  FIELD_W*NFIELD  received word; field i = data[FIELD_W*(i+1)-1 : FIELD_W*i].
REQ-011 pop  in  1  data valid this cycle.
REQ-012 error  in  1  upstream flags word as corrupt.
REQ-013 ts_mode  in  1  low TS_F fields hold timestamp in data[TS_W-1:0], quasi-static.
REQ-014 now  in  TS_W  free-running time base, same units as timestamp.
REQ-015 chk_valid  out  1  one-cycle pulse, result for a popped word.
REQ-016 chk_ok  out  1  result of that word, valid with chk_valid.
REQ-017 locked  out  1  state == LOCKED.
REQ-018 err_cnt  out  32  mismatches while LOCKED, error=0.
REQ-019 excused_cnt  out  32  mismatches with error=1.
REQ-020 word_cnt  out  32  total pops.
REQ-021 lat_min, lat_max  out  TS_W  latency extremes.
REQ-022 bw_cycles  out  32  cycles spanned by last window; bw_valid out 1 pulse on update.

Function
REQ-023 Word good: field i == base+i+1 mod 2^FIELD_W for every checked i, and (base+1) mod NFIELD == 0; base = field NFIELD-1 of previous popped word.
REQ-024 Checked fields: all when ts_mode=0; i >= TS_F when ts_mode=1 (alignment still computed from base).
REQ-025 base updates to current top field on every pop, good or bad, error or not.
REQ-026 chk_valid/chk_ok registered: asserted the cycle after the pop; no output on idle cycles.
REQ-027 States HUNT, SYNC, LOCKED; reset to HUNT.
REQ-028 HUNT: first pop loads base only, -> SYNC with good_run=0; chk_ok=1.
REQ-029 SYNC: good word increments good_run; reaching LOCK_CNT -> LOCKED; bad word clears good_run, stays SYNC; chk_ok=1 in SYNC.
REQ-030 LOCKED: chk_ok = good | error; bad & !error -> err_cnt+1, bad_run+1; bad & error -> excused_cnt+1, bad_run unchanged; good clears bad_run; bad_run reaching LOSS_CNT -> HUNT.
REQ-031 All 32-bit counters saturate at all-ones.
REQ-032 Latency: on pop & good & ts_mode & LOCKED, lat = now - data[TS_W-1:0] mod 2^TS_W; lat > 0 and lat < lat_min -> lat_min = lat; lat < LAT_CAP and lat > lat_max -> lat_max = lat.
REQ-033 Bandwidth: cycle counter runs from first pop after reset; after every WIN pops (incl. error words) bw_cycles = cycles since previous window boundary, bw_valid pulses 1 cycle, counter restarts.
REQ-034 Field arithmetic wraps at 2^FIELD_W; wrap of base (e.g. 0xFF0 -> 0x000) is good.

Reset
REQ-035 reset_n low, any time, immediately: state HUNT, all counters 0, lat_min all-ones, lat_max 0, chk_valid 0, chk_ok 0, bw_valid 0, locked 0, base 0.
REQ-036 Pop in reset-release cycle is processed normally as first HUNT word.

Verification
REQ-037 Defaults, ts_mode=0, words with field0 = 0x000,0x010,... each pop: locked rises after 5th word; chk_ok=1 always; err_cnt=0.
REQ-038 Locked stream, one word field7 corrupted, error=0: chk_ok=0 once, err_cnt=1, next correct word chk_ok=1, still locked.
REQ-039 Same corruption with error=1: chk_ok=1, excused_cnt=1, err_cnt=0.
REQ-040 8 consecutive bad words error=0: locked falls after 8th; err_cnt=8; subsequent clean stream relocks after 1+4 words.
REQ-041 ts_mode=1, timestamp = now-20 then now-7: lat_min=7, lat_max=20; sample 60 leaves lat_max=20.
REQ-042 Pops every 2nd cycle, WIN=1000: bw_cycles=2000, bw_valid pulse; reset_n asserted mid-window clears all, base wrap 0xFF0->0x000 gives chk_ok=1.

Source files
------------

// File: rtl/seq_chk_param_if.sv
//------------------------------------------------------------------------------
// Module     : seq_chk_param_if
// Description: Word stream and result bundle between a source and the
//              sequence checker.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seq_chk_param_if #(
    parameter int FIELD_W = 12,
    parameter int NFIELD  = 16,
    parameter int TS_W    = 32
);
    logic [FIELD_W*NFIELD-1:0] data;
    logic                      pop;
    logic                      error;
    logic                      ts_mode;
    logic [TS_W-1:0]           now;

    logic                      chk_valid;
    logic                      chk_ok;
    logic                      locked;
    logic [31:0]               err_cnt;
    logic [31:0]               excused_cnt;
    logic [31:0]               word_cnt;
    logic [TS_W-1:0]           lat_min;
    logic [TS_W-1:0]           lat_max;
    logic [31:0]               bw_cycles;
    logic                      bw_valid;

    modport master (
        output data, pop, error, ts_mode, now,
        input  chk_valid, chk_ok, locked, err_cnt, excused_cnt, word_cnt,
               lat_min, lat_max, bw_cycles, bw_valid
    );

    modport slave (
        input  data, pop, error, ts_mode, now,
        output chk_valid, chk_ok, locked, err_cnt, excused_cnt, word_cnt,
               lat_min, lat_max, bw_cycles, bw_valid
    );
endinterface

`default_nettype wire

// File: rtl/seq_chk_param.sv
//------------------------------------------------------------------------------
// Module     : seq_chk_param
// Description: Incrementing-field sequence checker with lock tracking,
//              latency extremes and bandwidth window measurement.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seq_chk_param #(
    parameter int FIELD_W  = 12,
    parameter int NFIELD   = 16,
    parameter int TS_W     = 32,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 8,
    parameter int WIN      = 1000,
    parameter int LAT_CAP  = 50
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    seq_chk_param_if.slave bus
);

    localparam int c_TS_F    = (TS_W + FIELD_W - 1) / FIELD_W;
    localparam int c_AL_W    = $clog2(NFIELD);
    localparam int c_RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int c_RUN_W   = $clog2(c_RUN_MAX + 1);
    localparam int c_WIN_W   = $clog2(WIN + 1);

    localparam logic [c_RUN_W-1:0] c_LOCK_LAST = c_RUN_W'(LOCK_CNT - 1);
    localparam logic [c_RUN_W-1:0] c_LOSS_LAST = c_RUN_W'(LOSS_CNT - 1);
    localparam logic [c_WIN_W-1:0] c_WIN_LAST  = c_WIN_W'(WIN - 1);
    localparam logic [TS_W-1:0]    c_LAT_CAP   = TS_W'(LAT_CAP);

    localparam logic [1:0] c_ST_HUNT   = 2'd0;
    localparam logic [1:0] c_ST_SYNC   = 2'd1;
    localparam logic [1:0] c_ST_LOCKED = 2'd2;

    logic [1:0]          r_state;
    logic                r_locked;
    logic [FIELD_W-1:0]  r_base;
    logic [c_RUN_W-1:0]  r_good_run;
    logic [c_RUN_W-1:0]  r_bad_run;
    logic                r_chk_valid;
    logic                r_chk_ok;
    logic [31:0]         r_err_cnt;
    logic [31:0]         r_excused_cnt;
    logic [31:0]         r_word_cnt;
    logic [TS_W-1:0]     r_lat_min;
    logic [TS_W-1:0]     r_lat_max;
    logic                r_bw_run;
    logic [31:0]         r_cyc;
    logic [c_WIN_W-1:0]  r_win_cnt;
    logic [31:0]         r_bw_cycles;
    logic                r_bw_valid;

    logic [NFIELD-1:0]   w_fld_ok;
    logic [FIELD_W-1:0]  w_base_inc;
    logic                w_aligned;
    logic                w_good;
    logic [FIELD_W-1:0]  w_top;
    logic [TS_W-1:0]     w_lat;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Timestamp fields are exempt from the value check but not from alignment.
    generate
        for (genvar gi = 0; gi < NFIELD; gi++) begin : g_fld
            localparam logic [FIELD_W-1:0] c_OFS    = FIELD_W'(gi + 1);
            localparam bit                 c_TS_FLD = (gi < c_TS_F);
            logic w_eq;
            assign w_eq         = (bus.data[FIELD_W*gi +: FIELD_W] == (r_base + c_OFS));
            assign w_fld_ok[gi] = w_eq | (c_TS_FLD & bus.ts_mode);
        end
    endgenerate

    assign w_base_inc = r_base + FIELD_W'(1);
    assign w_aligned  = (w_base_inc[c_AL_W-1:0] == '0);
    assign w_good     = (&w_fld_ok) & w_aligned;
    assign w_top      = bus.data[FIELD_W*NFIELD-1 -: FIELD_W];
    assign w_lat      = bus.now - bus.data[TS_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_ST_HUNT;
            r_locked      <= 1'b0;
            r_base        <= '0;
            r_good_run    <= '0;
            r_bad_run     <= '0;
            r_chk_valid   <= 1'b0;
            r_chk_ok      <= 1'b0;
            r_err_cnt     <= '0;
            r_excused_cnt <= '0;
            r_word_cnt    <= '0;
            r_lat_min     <= '1;
            r_lat_max     <= '0;
        end else begin
            r_chk_valid <= bus.pop;
            r_chk_ok    <= 1'b0;
            if (bus.pop) begin
                r_base     <= w_top;
                r_word_cnt <= sat_inc(r_word_cnt);
                case (r_state)
                    c_ST_HUNT: begin
                        r_state    <= c_ST_SYNC;
                        r_good_run <= '0;
                        r_chk_ok   <= 1'b1;
                    end
                    c_ST_SYNC: begin
                        r_chk_ok <= 1'b1;
                        if (!w_good) begin
                            r_good_run <= '0;
                        end else if (r_good_run == c_LOCK_LAST) begin
                            r_state   <= c_ST_LOCKED;
                            r_locked  <= 1'b1;
                            r_bad_run <= '0;
                        end else begin
                            r_good_run <= r_good_run + c_RUN_W'(1);
                        end
                    end
                    c_ST_LOCKED: begin
                        r_chk_ok <= w_good | bus.error;
                        if (w_good) begin
                            r_bad_run <= '0;
                            if (bus.ts_mode) begin
                                if ((w_lat != '0) && (w_lat < r_lat_min))
                                    r_lat_min <= w_lat;
                                if ((w_lat < c_LAT_CAP) && (w_lat > r_lat_max))
                                    r_lat_max <= w_lat;
                            end
                        end else if (bus.error) begin
                            r_excused_cnt <= sat_inc(r_excused_cnt);
                        end else begin
                            r_err_cnt <= sat_inc(r_err_cnt);
                            if (r_bad_run == c_LOSS_LAST) begin
                                r_state  <= c_ST_HUNT;
                                r_locked <= 1'b0;
                            end else begin
                                r_bad_run <= r_bad_run + c_RUN_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state  <= c_ST_HUNT;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Window boundary is the pop that completes a window; the first window
    // is measured from the first pop after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bw_run    <= 1'b0;
            r_cyc       <= '0;
            r_win_cnt   <= '0;
            r_bw_cycles <= '0;
            r_bw_valid  <= 1'b0;
        end else begin
            r_bw_valid <= 1'b0;
            if (!r_bw_run) begin
                if (bus.pop) begin
                    r_bw_run  <= 1'b1;
                    r_cyc     <= '0;
                    r_win_cnt <= c_WIN_W'(1);
                end
            end else if (bus.pop && (r_win_cnt == c_WIN_LAST)) begin
                r_bw_cycles <= sat_inc(r_cyc);
                r_bw_valid  <= 1'b1;
                r_cyc       <= '0;
                r_win_cnt   <= '0;
            end else begin
                r_cyc <= sat_inc(r_cyc);
                if (bus.pop)
                    r_win_cnt <= r_win_cnt + c_WIN_W'(1);
            end
        end
    end

    assign bus.chk_valid   = r_chk_valid;
    assign bus.chk_ok      = r_chk_ok;
    assign bus.locked      = r_locked;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.excused_cnt = r_excused_cnt;
    assign bus.word_cnt    = r_word_cnt;
    assign bus.lat_min     = r_lat_min;
    assign bus.lat_max     = r_lat_max;
    assign bus.bw_cycles   = r_bw_cycles;
    assign bus.bw_valid    = r_bw_valid;

endmodule

`default_nettype wire
